// File: rtl/wb_bus_arbiter_if.sv
// Writeback bus bundle between the FU wrappers, the arbiter and the ROB/PRF/issue queue.
//   fu_*          : per-FU completion request (valid/ready, inst id, PRN write slots)
//   wb_*          : granted completion handshake towards the ROB
//   prf_write_*   : register-file write strobes, addresses and data
//   set_prn*      : issue-queue wakeup broadcast
// modport master : arbiter side; modport slave : FUs + ROB/PRF side.
interface wb_bus_arbiter_if #(
  parameter int unsigned INST_ID_BITS = 6,
  parameter int unsigned PRN_BITS     = 6,
  parameter int unsigned MAX_OPERANDS = 3,
  parameter int unsigned FU_COUNT     = 4
);
  localparam int unsigned FUC_BITS  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int unsigned DATA_BITS = 64;

  logic [FU_COUNT-1:0]                                   fu_valid;
  logic [FU_COUNT-1:0]                                   fu_ready;
  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]                 fu_inst_id;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                 fu_prn_valid;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]   fu_prn;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0]  fu_data;

  logic                                    wb_ready;
  logic                                    wb_valid;
  logic [INST_ID_BITS-1:0]                 wb_inst_id;
  logic [FUC_BITS-1:0]                     wb_fu_idx;
  logic [MAX_OPERANDS-1:0]                 prf_write_enable;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prf_write_prn;
  logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]  prf_write;
  logic [MAX_OPERANDS-1:0]                 set_prn_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   set_prn;

  modport master (
    input  fu_valid, fu_inst_id, fu_prn_valid, fu_prn, fu_data, wb_ready,
    output fu_ready, wb_valid, wb_inst_id, wb_fu_idx,
           prf_write_enable, prf_write_prn, prf_write, set_prn_ready, set_prn
  );

  modport slave (
    output fu_valid, fu_inst_id, fu_prn_valid, fu_prn, fu_data, wb_ready,
    input  fu_ready, wb_valid, wb_inst_id, wb_fu_idx,
           prf_write_enable, prf_write_prn, prf_write, set_prn_ready, set_prn
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin writeback bus arbiter: buffers one completion per FU and puts one
// granted completion per cycle on the PRF write / wakeup / ROB handshake bus.
//   clk  : clock
//   rst  : asynchronous active-high reset, discards all buffered completions
//   bus  : wb_bus_arbiter_if.master (FU requests in, writeback bus out)
module wb_bus_arbiter #(
  parameter int unsigned INST_ID_BITS = 6,
  parameter int unsigned PRN_BITS     = 6,
  parameter int unsigned MAX_OPERANDS = 3,
  parameter int unsigned FU_COUNT     = 4
) (
  input logic              clk,
  input logic              rst,
  wb_bus_arbiter_if.master bus
);
  localparam int unsigned FUC_BITS  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int unsigned DATA_BITS = 64;

  typedef enum logic {ST_OPEN, ST_LOCKED} state_e;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]                 inst_id;
    logic [MAX_OPERANDS-1:0]                 prn_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prn;
    logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]  data;
  } entry_t;

  state_e                    state_q, state_d;
  logic [FU_COUNT-1:0]       occ_q, occ_d;
  entry_t [FU_COUNT-1:0]     buf_q, buf_d;
  logic [FUC_BITS-1:0]       rr_q, rr_d;
  logic [FUC_BITS-1:0]       lock_idx_q, lock_idx_d;

  logic [FUC_BITS-1:0]       scan_c;
  logic [FUC_BITS-1:0]       grant_c;
  logic                      valid_c;
  logic                      fire_c;
  logic [FU_COUNT-1:0]       fu_ready_c;
  entry_t                    sel_c;

  // Round-robin scan starting at rr_q; a stalled grant stays locked so the bus holds steady.
  always_comb begin
    logic                found;
    logic [FUC_BITS-1:0] idx;
    scan_c = rr_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < FU_COUNT; k++) begin
      idx = FUC_BITS'((32'(rr_q) + k) % FU_COUNT);
      if (!found && occ_q[idx]) begin
        scan_c = idx;
        found  = 1'b1;
      end
    end
    grant_c = (state_q == ST_LOCKED) ? lock_idx_q : scan_c;
  end

  // Handshake, buffer capture/drain, lock FSM and bus outputs.
  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    buf_d      = buf_q;
    rr_d       = rr_q;
    lock_idx_d = lock_idx_q;

    valid_c = |occ_q;
    fire_c  = valid_c & bus.wb_ready;
    sel_c   = buf_q[grant_c];

    // A buffer being drained this cycle can be refilled on the same edge.
    fu_ready_c = '0;
    for (int i = 0; i < FU_COUNT; i++) begin
      fu_ready_c[i] = !occ_q[i] || (fire_c && (grant_c == FUC_BITS'(i)));
      if (fire_c && (grant_c == FUC_BITS'(i))) begin
        occ_d[i] = 1'b0;
      end
      if (bus.fu_valid[i] && fu_ready_c[i]) begin
        occ_d[i]           = 1'b1;
        buf_d[i].inst_id   = bus.fu_inst_id[i];
        buf_d[i].prn_valid = bus.fu_prn_valid[i];
        buf_d[i].prn       = bus.fu_prn[i];
        buf_d[i].data      = bus.fu_data[i];
      end
    end

    case (state_q)
      ST_OPEN: begin
        if (valid_c && !bus.wb_ready) begin
          state_d    = ST_LOCKED;
          lock_idx_d = grant_c;
        end
      end
      ST_LOCKED: begin
        if (fire_c) begin
          state_d = ST_OPEN;
        end
      end
      default: state_d = ST_OPEN;
    endcase

    if (fire_c) begin
      rr_d = (grant_c == FUC_BITS'(FU_COUNT - 1)) ? '0 : FUC_BITS'(grant_c + FUC_BITS'(1));
    end

    bus.fu_ready         = fu_ready_c;
    bus.wb_valid         = valid_c;
    bus.wb_inst_id       = '0;
    bus.wb_fu_idx        = '0;
    bus.prf_write_prn    = '0;
    bus.set_prn          = '0;
    bus.prf_write        = '0;
    bus.prf_write_enable = '0;
    bus.set_prn_ready    = '0;
    if (valid_c) begin
      bus.wb_inst_id    = sel_c.inst_id;
      bus.wb_fu_idx     = grant_c;
      bus.prf_write_prn = sel_c.prn;
      bus.set_prn       = sel_c.prn;
      bus.prf_write     = sel_c.data;
    end
    // Strobes only on an accepted transfer; a stalled bus never writes or wakes up.
    if (fire_c) begin
      bus.prf_write_enable = sel_c.prn_valid;
      bus.set_prn_ready    = sel_c.prn_valid;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_OPEN;
      occ_q      <= '0;
      buf_q      <= '0;
      rr_q       <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      buf_q      <= buf_d;
      rr_q       <= rr_d;
      lock_idx_q <= lock_idx_d;
    end
  end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Testbench for wb_bus_arbiter: FU stimulus per scenario, expected completions
// queued in bus order and compared as each one is accepted on the bus.
module tb_wb_bus_arbiter;
  localparam int unsigned INST_ID_BITS = 6;
  localparam int unsigned PRN_BITS     = 6;
  localparam int unsigned MAX_OPERANDS = 3;
  localparam int unsigned FU_COUNT     = 4;
  localparam int unsigned FUC_BITS     = 2;

  typedef struct {
    int              fu;
    logic [5:0]      id;
    logic [2:0]      pv;
    logic [2:0][5:0] prn;
    logic [2:0][63:0] data;
  } comp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    errors = 0;
  comp_t sb[$];
  comp_t plan[4][8];
  int    plan_n[4];

  wb_bus_arbiter_if #(
    .INST_ID_BITS(INST_ID_BITS), .PRN_BITS(PRN_BITS),
    .MAX_OPERANDS(MAX_OPERANDS), .FU_COUNT(FU_COUNT)
  ) bus ();

  wb_bus_arbiter #(
    .INST_ID_BITS(INST_ID_BITS), .PRN_BITS(PRN_BITS),
    .MAX_OPERANDS(MAX_OPERANDS), .FU_COUNT(FU_COUNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic comp_t mk(input int fu, input int id, input logic [2:0] pv);
    comp_t c;
    c.fu = fu;
    c.id = 6'(id);
    c.pv = pv;
    for (int k = 0; k < 3; k++) begin
      c.prn[k]  = 6'(id * 3 + k + 1);
      c.data[k] = {32'hC0DE_0000 | 32'(fu), 32'(id * 16 + k)};
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input comp_t c);
    bus.fu_valid[c.fu]     = 1'b1;
    bus.fu_inst_id[c.fu]   = c.id;
    bus.fu_prn_valid[c.fu] = c.pv;
    bus.fu_prn[c.fu]       = c.prn;
    bus.fu_data[c.fu]      = c.data;
  endtask

  task automatic release_fu(input int f);
    bus.fu_valid[f]     = 1'b0;
    bus.fu_inst_id[f]   = '0;
    bus.fu_prn_valid[f] = '0;
    bus.fu_prn[f]       = '0;
    bus.fu_data[f]      = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: every accepted bus transfer must match the next expected completion.
  task automatic scoreboard_monitor();
    comp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.wb_valid && bus.wb_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: got fu=%0d id=%0d, required no transfer",
                   bus.wb_fu_idx, bus.wb_inst_id);
        end else begin
          e = sb.pop_front();
          if (bus.wb_fu_idx !== FUC_BITS'(e.fu) || bus.wb_inst_id !== e.id ||
              bus.prf_write_enable !== e.pv || bus.set_prn_ready !== e.pv ||
              bus.prf_write_prn !== e.prn || bus.set_prn !== e.prn ||
              bus.prf_write !== e.data) begin
            errors++;
            $display("FAIL bus_payload: got fu=%0d id=%0d en=%b set=%b prn=%h wk=%h data=%h, required fu=%0d id=%0d en=%b prn=%h data=%h",
                     bus.wb_fu_idx, bus.wb_inst_id, bus.prf_write_enable, bus.set_prn_ready,
                     bus.prf_write_prn, bus.set_prn, bus.prf_write, e.fu, e.id, e.pv, e.prn, e.data);
          end
        end
      end else if (!rst && bus.wb_valid) begin
        checks++;
        if (bus.prf_write_enable !== '0 || bus.set_prn_ready !== '0) begin
          errors++;
          $display("FAIL stall_strobes: got en=%b set=%b, required 000/000",
                   bus.prf_write_enable, bus.set_prn_ready);
        end
      end else if (!rst) begin
        checks++;
        if (bus.wb_inst_id !== '0 || bus.wb_fu_idx !== '0 || bus.prf_write_enable !== '0 ||
            bus.set_prn_ready !== '0 || bus.prf_write_prn !== '0 || bus.set_prn !== '0 ||
            bus.prf_write !== '0) begin
          errors++;
          $display("FAIL idle_zero: got id=%0d fu=%0d en=%b set=%b prn=%h data=%h, required all 0",
                   bus.wb_inst_id, bus.wb_fu_idx, bus.prf_write_enable, bus.set_prn_ready,
                   bus.prf_write_prn, bus.prf_write);
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d completions still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Presents each FU's planned completions back to back, advancing on fu_ready.
  task automatic drive_all(input int budget);
    int         pos[4];
    logic [3:0] rdy;
    int         n = 0;
    bit         busy = 1'b1;
    pos = '{default: 0};
    while (busy && n < budget) begin
      busy = 1'b0;
      for (int f = 0; f < 4; f++) begin
        if (pos[f] < plan_n[f]) begin
          present(plan[f][pos[f]]);
          busy = 1'b1;
        end else begin
          release_fu(f);
        end
      end
      if (busy) begin
        @(negedge clk);
        rdy = bus.fu_ready;
        tick();
        for (int f = 0; f < 4; f++) begin
          if (pos[f] < plan_n[f] && rdy[f]) pos[f]++;
        end
        n++;
      end
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drive_timeout: got FUs still waiting after %0d cycles, required all accepted", n);
    end
  endtask

  task automatic test_reset();
    bus.fu_valid = '0; bus.fu_inst_id = '0; bus.fu_prn_valid = '0;
    bus.fu_prn = '0; bus.fu_data = '0; bus.wb_ready = 1'b0;
    #12;
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.prf_write_enable !== '0 || bus.set_prn_ready !== '0 ||
        bus.wb_inst_id !== '0 || bus.wb_fu_idx !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b en=%b set=%b id=%0d fu=%0d, required 0",
               bus.wb_valid, bus.prf_write_enable, bus.set_prn_ready, bus.wb_inst_id, bus.wb_fu_idx);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fu_ready !== 4'hF || bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got ready=%b valid=%b, required 1111 0", bus.fu_ready, bus.wb_valid);
    end
    tick();
  endtask

  task automatic test_single();
    comp_t c;
    bus.wb_ready = 1'b1;
    c = mk(2, 5, 3'b001);
    c.prn[0]  = 6'd12;
    c.data[0] = 64'hDEAD;
    present(c);
    sb.push_back(c);
    @(negedge clk);
    checks++;
    if (bus.fu_ready[2] !== 1'b1 || bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got ready2=%b valid=%b, required 1 0", bus.fu_ready[2], bus.wb_valid);
    end
    tick();
    release_fu(2);
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got valid=%b, required 1", bus.wb_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got valid=%b, required 0", bus.wb_valid);
    end
    // Pointer now sits at FU3, so FU3 must win over FU0.
    tick();
    present(mk(0, 6, 3'b010));
    present(mk(3, 7, 3'b100));
    sb.push_back(mk(3, 7, 3'b100));
    sb.push_back(mk(0, 6, 3'b010));
    tick();
    release_fu(0);
    release_fu(3);
    wait_drain("single_rr");
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_rdy[4] = '{4'b1111, 4'b0101, 4'b0111, 4'b1111};
    apply_reset();
    bus.wb_ready = 1'b1;
    present(mk(0, 1, 3'b001));
    present(mk(1, 2, 3'b011));
    present(mk(3, 3, 3'b111));
    sb.push_back(mk(0, 1, 3'b001));
    sb.push_back(mk(1, 2, 3'b011));
    sb.push_back(mk(3, 3, 3'b111));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.fu_ready !== exp_rdy[i]) begin
        errors++;
        $display("FAIL simul_ready%0d: got %b, required %b", i, bus.fu_ready, exp_rdy[i]);
      end
      tick();
      if (i == 0) begin
        release_fu(0);
        release_fu(1);
        release_fu(3);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL simul_done: got valid=%b pending=%0d, required 0 0", bus.wb_valid, sb.size());
    end
    tick();
  endtask

  task automatic test_fairness();
    apply_reset();
    bus.wb_ready = 1'b1;
    plan_n = '{4, 4, 0, 0};
    for (int j = 0; j < 4; j++) begin
      plan[0][j] = mk(0, 10 + 2 * j, 3'b001);
      plan[1][j] = mk(1, 11 + 2 * j, 3'b010);
      sb.push_back(plan[0][j]);
      sb.push_back(plan[1][j]);
    end
    drive_all(30);
    wait_drain("fair");
  endtask

  task automatic test_stall();
    apply_reset();
    bus.wb_ready = 1'b1;
    present(mk(2, 20, 3'b011));
    sb.push_back(mk(2, 20, 3'b011));
    sb.push_back(mk(0, 21, 3'b101));
    tick();
    release_fu(2);
    present(mk(0, 21, 3'b101));
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_fu_idx !== 2'd2 || bus.wb_inst_id !== 6'd20) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b fu=%0d id=%0d, required 1 2 20",
                 i, bus.wb_valid, bus.wb_fu_idx, bus.wb_inst_id);
      end
      tick();
      if (i == 0) release_fu(0);
    end
    bus.wb_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_drain_refill();
    bus.wb_ready = 1'b1;
    present(mk(1, 8, 3'b001));
    sb.push_back(mk(1, 8, 3'b001));
    sb.push_back(mk(1, 9, 3'b110));
    tick();
    present(mk(1, 9, 3'b110));
    @(negedge clk);
    checks++;
    if (bus.fu_ready[1] !== 1'b1 || bus.wb_inst_id !== 6'd8) begin
      errors++;
      $display("FAIL refill_ready: got ready1=%b id=%0d, required 1 8", bus.fu_ready[1], bus.wb_inst_id);
    end
    tick();
    release_fu(1);
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_inst_id !== 6'd9) begin
      errors++;
      $display("FAIL refill_bubble: got valid=%b id=%0d, required 1 9", bus.wb_valid, bus.wb_inst_id);
    end
    tick();
    wait_drain("refill");
  endtask

  task automatic test_reset_mid();
    bus.wb_ready = 1'b0;
    present(mk(0, 30, 3'b111));
    present(mk(1, 31, 3'b111));
    present(mk(2, 32, 3'b111));
    tick();
    release_fu(0);
    release_fu(1);
    release_fu(2);
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.fu_ready[2:0] !== 3'b000) begin
      errors++;
      $display("FAIL midrst_fill: got valid=%b ready=%b, required 1 x000", bus.wb_valid, bus.fu_ready);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.wb_ready = 1'b1;
    #1;
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.prf_write_enable !== '0 || bus.set_prn_ready !== '0 ||
        bus.wb_inst_id !== '0 || bus.wb_fu_idx !== '0 || bus.fu_ready !== 4'hF) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b en=%b set=%b id=%0d fu=%0d ready=%b, required 0 000 000 0 0 1111",
               bus.wb_valid, bus.prf_write_enable, bus.set_prn_ready, bus.wb_inst_id,
               bus.wb_fu_idx, bus.fu_ready);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale%0d: got valid=%b id=%0d, required 0", i, bus.wb_valid, bus.wb_inst_id);
      end
    end
    // Pointer back at 0: FU0 must beat FU3.
    tick();
    present(mk(0, 33, 3'b001));
    present(mk(3, 34, 3'b001));
    sb.push_back(mk(0, 33, 3'b001));
    sb.push_back(mk(3, 34, 3'b001));
    tick();
    release_fu(0);
    release_fu(3);
    wait_drain("midrst");
  endtask

  initial begin
    fork
      scoreboard_monitor();
      begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_stall();
        test_drain_refill();
        test_reset_mid();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join_any
  end
endmodule
